// File: rtl/ex_muldiv_if.sv
// Request/response bundle between ID/EX and the multiply/divide unit.
// The master side issues operations and consumes results.
interface ex_muldiv_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) ();
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_funct3;
    logic [XLEN-1:0]  in_rs1;
    logic [XLEN-1:0]  in_rs2;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_funct3, in_rs1, in_rs2, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    modport slave (
        input  in_valid, in_funct3, in_rs1, in_rs2, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );
endinterface

// File: rtl/ex_muldiv.sv
// RV32M multi-cycle execute unit: fixed-latency multiply, restoring
// divide (one quotient bit per cycle), tagged result with flush.
module ex_muldiv #(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 2,
    parameter int TAG_W   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    ex_muldiv_if.slave io
);
    localparam int CNT_W = $clog2(XLEN + MUL_LAT + 1);
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = '1;

    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  dvs_q, dvs_d;
    logic             is_rem_q, is_rem_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]  res_q, res_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             valid_q, valid_d;

    logic              accept;
    logic              div_signed;
    logic              a_neg, b_neg;
    logic              mul_sa, mul_sb;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [2*XLEN-1:0] a_ext, b_ext, prod;
    logic [XLEN:0]     trial, trial_sub;

    assign io.in_ready   = (state_q == IDLE);
    assign io.out_valid  = valid_q;
    assign io.out_result = res_q;
    assign io.out_tag    = tag_q;
    assign accept = io.in_valid & io.in_ready & ~flush;

    always_comb begin
        div_signed = ~io.in_funct3[0];
        a_neg  = div_signed & io.in_rs1[XLEN-1];
        b_neg  = div_signed & io.in_rs2[XLEN-1];
        a_mag  = a_neg ? -io.in_rs1 : io.in_rs1;
        b_mag  = b_neg ? -io.in_rs2 : io.in_rs2;
        mul_sa = (io.in_funct3[1:0] == 2'b01) || (io.in_funct3[1:0] == 2'b10);
        mul_sb = (io.in_funct3[1:0] == 2'b01);
        a_ext  = {{XLEN{mul_sa & io.in_rs1[XLEN-1]}}, io.in_rs1};
        b_ext  = {{XLEN{mul_sb & io.in_rs2[XLEN-1]}}, io.in_rs2};
        prod   = a_ext * b_ext;
        // Partial remainder stays below the divisor, so XLEN+1 bits suffice.
        trial     = {rem_q, quo_q[XLEN-1]};
        trial_sub = trial - {1'b0, dvs_q};
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        is_rem_d  = is_rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        res_d     = res_q;
        tag_d     = tag_q;
        valid_d   = valid_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    tag_d = io.in_tag;
                    if (!io.in_funct3[2]) begin
                        res_d = (io.in_funct3[1:0] == 2'b00) ? prod[XLEN-1:0]
                                                             : prod[2*XLEN-1:XLEN];
                        if (MUL_LAT == 1) begin
                            state_d = DONE;
                            valid_d = 1'b1;
                        end else begin
                            state_d = MUL;
                            cnt_d   = CNT_W'(MUL_LAT - 1);
                        end
                    end else if (io.in_rs2 == '0) begin
                        res_d   = io.in_funct3[1] ? io.in_rs1 : ALL_ONES;
                        state_d = DONE;
                        valid_d = 1'b1;
                    end else if (div_signed && io.in_rs1 == MIN_NEG &&
                                 io.in_rs2 == ALL_ONES) begin
                        res_d   = io.in_funct3[1] ? '0 : io.in_rs1;
                        state_d = DONE;
                        valid_d = 1'b1;
                    end else begin
                        state_d   = DIV;
                        cnt_d     = CNT_W'(XLEN - 1);
                        rem_d     = '0;
                        quo_d     = a_mag;
                        dvs_d     = b_mag;
                        is_rem_d  = io.in_funct3[1];
                        neg_quo_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                    end
                end
            end
            MUL: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                end
            end
            DIV: begin
                if (!trial_sub[XLEN]) begin
                    rem_d = trial_sub[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_d = trial[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b0};
                end
                if (cnt_q == '0) state_d = FIX;
                else cnt_d = cnt_q - 1'b1;
            end
            FIX: begin
                if (is_rem_q) res_d = neg_rem_q ? -rem_q : rem_q;
                else res_d = neg_quo_q ? -quo_q : quo_q;
                state_d = DONE;
                valid_d = 1'b1;
            end
            DONE: begin
                if (io.out_ready) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
        if (flush) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            is_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            res_q     <= '0;
            tag_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            is_rem_q  <= is_rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            res_q     <= res_d;
            tag_q     <= tag_d;
            valid_q   <= valid_d;
        end
    end
endmodule
